// File: rtl/pe_output_packer_pkg.sv
// Shared widths, state encoding and FIFO entry layout for the PE output packer.
package pe_output_packer_pkg;

    localparam int unsigned ACC_DATA_WIDTH = 32;
    localparam int unsigned ACT_DATA_WIDTH = 8;
    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned LANES          = WORD_WIDTH / ACT_DATA_WIDTH;
    localparam int unsigned LANE_IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned CNT_WIDTH      = 16;
    localparam int unsigned HI_W           = ACC_DATA_WIDTH - ACT_DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DRAIN,
        DONE
    } packer_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LANES-1:0]      strb;
    } word_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(word_entry_t);

    // A value fits the signed activation range iff its sign-extension bits all agree.
    function automatic logic act_overflow(input logic [HI_W-1:0] hi);
        return !((&hi) || !(|hi));
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so the head is read straight from a flop.
module packer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop_c, push_c;
    logic [CNT_W-1:0] wr_idx_c;

    always_comb begin
        pop_c    = pop && !empty_q;
        push_c   = push && (!full_q || pop_c);
        mem_d    = mem_q;
        wr_idx_c = pop_c ? (count_q - CNT_W'(1)) : count_q;
        if (pop_c) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[DEPTH-1] = '0;
        end
        if (push_c) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx_c) begin
                    mem_d[i] = push_data;
                end
            end
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign head_data = mem_q[0];
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;

endmodule

// File: rtl/pe_output_packer.sv
// Packs truncated PE column outputs into addressed, strobed memory words and
// buffers them toward the activation-memory write port.
module pe_output_packer
    import pe_output_packer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_WIDTH-1:0]      cfg_num_values,
    input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
    input  logic                      in_valid,
    input  logic [ACC_DATA_WIDTH-1:0] in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WORD_WIDTH-1:0]     out_data,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [LANES-1:0]          out_strb,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      sat_error
);

    packer_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LANE_IDX_W-1:0]  lane_idx_q, lane_idx_d;
    logic [WORD_WIDTH-1:0]  lane_reg_q, lane_reg_d;
    logic                   sat_q, sat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept_c;
    logic                   pop_c;
    logic                   push_c;
    logic                   last_c;
    logic                   lane_full_c;
    logic [WORD_WIDTH-1:0]  lane_fill_c;
    logic [LANES-1:0]       strb_c;
    word_entry_t            push_entry_c;
    word_entry_t            head;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_CNT_W-1:0]  fifo_count;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready  = (state_q == PACK) && !fifo_full;
    assign out_valid = !fifo_empty;
    assign accept_c  = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        lane_idx_d   = lane_idx_q;
        lane_reg_d   = lane_reg_q;
        sat_d        = sat_q;
        push_c       = 1'b0;
        last_c       = (rem_q == CNT_WIDTH'(1));
        lane_full_c  = (lane_idx_q == LANE_IDX_W'(LANES - 1));
        lane_fill_c  = lane_reg_q;
        strb_c       = '0;
        for (int l = 0; l < LANES; l++) begin
            if (LANE_IDX_W'(l) == lane_idx_q) begin
                lane_fill_c[l*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = in_data[ACT_DATA_WIDTH-1:0];
            end
            strb_c[l] = (LANE_IDX_W'(l) <= lane_idx_q);
        end
        push_entry_c = '{data: lane_fill_c, addr: addr_q, strb: strb_c};

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = cfg_num_values;
                    addr_d     = cfg_base_addr;
                    lane_idx_d = '0;
                    lane_reg_d = '0;
                    sat_d      = 1'b0;
                    state_d    = (cfg_num_values == '0) ? DONE : PACK;
                end
            end
            PACK: begin
                if (accept_c) begin
                    if (act_overflow(in_data[ACC_DATA_WIDTH-1:ACT_DATA_WIDTH-1])) begin
                        sat_d = 1'b1;
                    end
                    rem_d = rem_q - CNT_WIDTH'(1);
                    if (lane_full_c || last_c) begin
                        push_c     = 1'b1;
                        addr_d     = addr_q + ADDR_WIDTH'(1);
                        lane_idx_d = '0;
                        lane_reg_d = '0;
                    end else begin
                        lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
                        lane_reg_d = lane_fill_c;
                    end
                    if (last_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave on the edge at which the FIFO runs dry.
                if ((fifo_count == '0) || ((fifo_count == FIFO_CNT_W'(1)) && pop_c)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            addr_q     <= '0;
            lane_idx_q <= '0;
            lane_reg_q <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            lane_idx_q <= lane_idx_d;
            lane_reg_q <= lane_reg_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    packer_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_entry_c),
        .pop       (pop_c),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_data  = head.data;
    assign out_addr  = head.addr;
    assign out_strb  = head.strb;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_error = sat_q;

endmodule

// File: tb/tb_pe_output_packer.sv
// Self-checking bench for pe_output_packer: tile-level word model plus directed literal checks.
module tb_pe_output_packer;

    typedef struct {
        logic [31:0] data;
        logic [15:0] addr;
        logic [3:0]  strb;
    } word_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] cfg_num_values;
    logic [15:0] cfg_base_addr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_addr;
    logic [3:0]  out_strb;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        sat_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int accepted_cnt = 0;
    int ready_mode = 0;

    logic [31:0] vals[$];
    word_t       exp_q[$];
    word_t       got_q[$];
    logic        exp_sat;

    bit          hold_prev = 0;
    word_t       prev_w;

    pe_output_packer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_num_values (cfg_num_values),
        .cfg_base_addr  (cfg_base_addr),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_addr       (out_addr),
        .out_strb       (out_strb),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .sat_error      (sat_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
        check({tag, "_out_addr"},  64'(out_addr),  64'd0);
        check({tag, "_out_strb"},  64'(out_strb),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_sat_error"}, 64'(sat_error), 64'd0);
    endtask

    // Tile model: group values four at a time, low byte per lane, consecutive addresses.
    function automatic void build_expected(input int n, input logic [15:0] base);
        exp_q.delete();
        exp_sat = 1'b0;
        for (int k = 0; k * 4 < n; k++) begin
            word_t w;
            w.data = 32'd0;
            w.strb = 4'd0;
            w.addr = base + 16'(k);
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = k * 4 + j;
                if (idx < n) begin
                    w.data = w.data | ({24'd0, vals[idx][7:0]} << (8 * j));
                    w.strb[j] = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            if ($signed(vals[i]) < -128 || $signed(vals[i]) > 127) exp_sat = 1'b1;
        end
    endfunction

    // Scoreboard: every handshaked word is compared against the model queue.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (in_valid && in_ready) accepted_cnt++;
            if (hold_prev) begin
                checks++;
                if (!out_valid || out_data !== prev_w.data || out_addr !== prev_w.addr ||
                    out_strb !== prev_w.strb) begin
                    errors++;
                    $display("FAIL stable_hold: got v=%b %h@%h/%h expected v=1 %h@%h/%h",
                             out_valid, out_data, out_addr, out_strb,
                             prev_w.data, prev_w.addr, prev_w.strb);
                end
            end
            if (out_valid && out_ready) begin
                word_t g;
                g.data = out_data;
                g.addr = out_addr;
                g.strb = out_strb;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h@%h/%h expected none", g.data, g.addr, g.strb);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    if (g.data !== e.data || g.addr !== e.addr || g.strb !== e.strb) begin
                        errors++;
                        $display("FAIL word: got %h@%h/%h expected %h@%h/%h",
                                 g.data, g.addr, g.strb, e.data, e.addr, e.strb);
                    end
                end
                got_q.push_back(g);
                last_pop_cyc = cyc;
            end
            hold_prev   = out_valid && !out_ready;
            prev_w.data = out_data;
            prev_w.addr = out_addr;
            prev_w.strb = out_strb;
        end
    end

    task automatic begin_tile(input int n, input logic [15:0] base);
        @(posedge clk);
        #1;
        got_q.delete();
        accepted_cnt = 0;
        build_expected(n, base);
        cfg_num_values = 16'(n);
        cfg_base_addr  = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            int t;
            t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            @(negedge clk);
            while (!in_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 2000 cycles");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic finish_tile(input int n);
        int t;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected 1 within 5000 cycles");
            return;
        end
        check("done_busy", 64'(busy), 64'd1);
        check("drained", 64'(exp_q.size()), 64'd0);
        check("sat_error", 64'(sat_error), 64'(exp_sat));
        if (n > 0) check("done_latency", 64'(cyc), 64'(last_pop_cyc + 1));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_fall", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cfg_num_values = 16'd0;
        cfg_base_addr  = 16'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two full words back to back.
        ready_mode = 0;
        vals.delete();
        for (int i = 1; i <= 8; i++) vals.push_back(32'(i));
        begin_tile(8, 16'h0010);
        @(negedge clk);
        check("busy_rise", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        send_range(0, 8, 0);
        finish_tile(8);
        check("t1_words", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("t1_w0_data", 64'(got_q[0].data), 64'h04030201);
            check("t1_w0_addr", 64'(got_q[0].addr), 64'h10);
            check("t1_w1_data", 64'(got_q[1].data), 64'h08070605);
            check("t1_w1_addr", 64'(got_q[1].addr), 64'h11);
            check("t1_w1_strb", 64'(got_q[1].strb), 64'hF);
        end

        // Partial last word.
        vals.delete();
        for (int i = 1; i <= 5; i++) vals.push_back(32'(i));
        begin_tile(5, 16'h0200);
        send_range(0, 5, 0);
        finish_tile(5);
        if (got_q.size() == 2) begin
            check("t2_w1_data", 64'(got_q[1].data), 64'h00000005);
            check("t2_w1_addr", 64'(got_q[1].addr), 64'h0201);
            check("t2_w1_strb", 64'(got_q[1].strb), 64'h1);
        end else check("t2_words", 64'(got_q.size()), 64'd2);

        // Saturation boundaries, plus a start pulse while busy that must be ignored.
        vals.delete();
        vals.push_back(32'hFFFFFFFF);
        vals.push_back(32'hFFFFFF80);
        vals.push_back(32'h0000007F);
        vals.push_back(32'h00000000);
        vals.push_back(32'd200);
        begin_tile(5, 16'h0300);
        send_range(0, 4, 0);
        check("sat_in_range", 64'(sat_error), 64'd0);
        cfg_num_values = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_ignored_busy", 64'(busy), 64'd1);
        check("start_ignored_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        send_range(4, 5, 0);
        check("sat_set", 64'(sat_error), 64'd1);
        finish_tile(5);
        if (got_q.size() == 2) begin
            check("sat_w0_data", 64'(got_q[0].data), 64'h007F80FF);
            check("sat_w1_data", 64'(got_q[1].data), 64'h000000C8);
        end else check("sat_words", 64'(got_q.size()), 64'd2);
        check("sat_sticky", 64'(sat_error), 64'd1);

        // Backpressure: FIFO fills to four words, then releases in order.
        ready_mode = 2;
        vals.delete();
        for (int i = 1; i <= 24; i++) vals.push_back(32'(i));
        begin_tile(24, 16'h0400);
        @(negedge clk);
        check("sat_cleared_by_start", 64'(sat_error), 64'd0);
        @(posedge clk);
        #1;
        fork
            send_range(0, 24, 0);
            begin
                repeat (30) @(negedge clk);
                check("bp_accepted", 64'(accepted_cnt), 64'd16);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_head", 64'(out_data), 64'h04030201);
                ready_mode = 0;
            end
        join
        finish_tile(24);
        check("bp_words", 64'(got_q.size()), 64'd6);
        if (got_q.size() == 6) check("bp_last_addr", 64'(got_q[5].addr), 64'h0405);

        // Empty tile.
        vals.delete();
        begin_tile(0, 16'h0055);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_no_words", 64'(got_q.size()), 64'd0);

        // Reset in the middle of a tile.
        vals.delete();
        for (int i = 1; i <= 16; i++) vals.push_back(32'(i));
        vals[2] = 32'd300;
        begin_tile(16, 16'h0100);
        send_range(0, 6, 0);
        check("pre_reset_sat", 64'(sat_error), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");
        vals.delete();
        for (int i = 9; i <= 12; i++) vals.push_back(32'(i));
        begin_tile(4, 16'h2345);
        send_range(0, 4, 0);
        finish_tile(4);
        check("rst_words", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            check("rst_w0_data", 64'(got_q[0].data), 64'h0C0B0A09);
            check("rst_w0_addr", 64'(got_q[0].addr), 64'h2345);
        end

        // Randomized tiles, the first one wrapping the address counter.
        for (int k = 0; k < 10; k++) begin
            int n;
            logic [15:0] base;
            n    = (k == 0) ? 8 : int'($urandom_range(1, 20));
            base = (k == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            ready_mode = (k == 0) ? 0 : int'($urandom_range(0, 1));
            vals.delete();
            for (int i = 0; i < n; i++) begin
                logic [31:0] v;
                if ($urandom_range(0, 3) == 0) v = $urandom;
                else v = 32'($urandom_range(0, 255)) - 32'd128;
                vals.push_back(v);
            end
            begin_tile(n, base);
            send_range(0, n, 1);
            finish_tile(n);
            if (k == 0 && got_q.size() == 2) check("wrap_addr", 64'(got_q[1].addr), 64'h0000);
        end

        ready_mode = 0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
